// File: rtl/usb_top_pkg.sv
// Shared constants and types for the USB full-speed raw packet capture block.
// Line-state encoding follows {D+, D-}; SYNC is stored first-received-bit-in-MSB.
package usb_top_pkg;

   localparam int unsigned SAMPLES_PER_BIT  = 4;
   localparam int unsigned BUS_RESET_CYCLES = 120;
   localparam logic [7:0]  SYNC_PATTERN     = 8'b0101_0100;

   typedef enum logic [1:0] {
      LineSe0 = 2'b00,
      LineK   = 2'b01,
      LineJ   = 2'b10
   } line_state_e;

   typedef enum logic [1:0] {
      StIdle,
      StSyncHunt,
      StReceive,
      StOverflow
   } cap_state_e;

   // (1,1) is illegal on the bus and is folded into SE0.
   function automatic line_state_e decode_line(input logic dp, input logic dn);
      line_state_e st;
      if (dp && !dn) begin
         st = LineJ;
      end else if (!dp && dn) begin
         st = LineK;
      end else begin
         st = LineSe0;
      end
      return st;
   endfunction

endpackage

// File: rtl/usb_fs_line_sampler.sv
// Synchronises D+/D-, recovers mid-bit sample points from line transitions and
// flags bus reset after a long SE0 run.
module usb_fs_line_sampler
   import usb_top_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic dp_i,
   input  logic dn_i,
   output logic bit_valid_o,
   output logic bit_o,
   output logic se0_o,
   output logic bus_reset_o
);

   localparam logic [1:0] SamplePhase = 2'(SAMPLES_PER_BIT / 2);
   localparam logic [7:0] Se0Max      = 8'(BUS_RESET_CYCLES);

   logic        dp_meta_q, dp_sync_q, dn_meta_q, dn_sync_q;
   line_state_e line_cur, line_prev_q;
   logic [1:0]  phase_q, phase_d;
   logic [7:0]  se0_cnt_q, se0_cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dp_meta_q   <= 1'b0;
         dp_sync_q   <= 1'b0;
         dn_meta_q   <= 1'b0;
         dn_sync_q   <= 1'b0;
         line_prev_q <= LineSe0;
         phase_q     <= 2'd0;
         se0_cnt_q   <= 8'd0;
      end else begin
         dp_meta_q   <= dp_i;
         dp_sync_q   <= dp_meta_q;
         dn_meta_q   <= dn_i;
         dn_sync_q   <= dn_meta_q;
         line_prev_q <= line_cur;
         phase_q     <= phase_d;
         se0_cnt_q   <= se0_cnt_d;
      end
   end

   // Phase is 0 in the cycle the new line state appears, so phase 2 is mid-bit.
   always_comb begin
      line_cur  = decode_line(dp_sync_q, dn_sync_q);
      phase_d   = (line_cur != line_prev_q) ? 2'd0 : phase_q + 2'd1;
      se0_cnt_d = se0_cnt_q;
      if (line_cur != LineSe0) begin
         se0_cnt_d = 8'd0;
      end else if (se0_cnt_q != Se0Max) begin
         se0_cnt_d = se0_cnt_q + 8'd1;
      end
   end

   assign bit_valid_o = (phase_d == SamplePhase);
   assign bit_o       = (line_cur == LineJ);
   assign se0_o       = (line_cur == LineSe0);
   // Saturating counter makes this a single pulse per SE0 run.
   assign bus_reset_o = (line_cur == LineSe0) && (se0_cnt_q == Se0Max - 8'd1);

endmodule

// File: rtl/usb_top.sv
// USB full-speed raw line-state packet capture: SYNC hunt, bitwise store into
// usb_packet_buffer, status LEDs for packet done / overflow / bus reset.
module usb_top
   import usb_top_pkg::*;
#(
   parameter int unsigned BUFFER_WORDS = 256
) (
   input  logic clock48,
   input  logic reset_n,
   input  logic data,
   input  logic data_n,
   output logic usb_pullup,
   output logic r,
   output logic g,
   output logic b
);

   localparam int unsigned BufferBits = BUFFER_WORDS * 32;
   localparam int unsigned BitIdxW    = $clog2(BufferBits) + 1;
   localparam int unsigned ByteCntW   = BitIdxW - 2;
   localparam int unsigned WordW      = $clog2(BUFFER_WORDS);
   localparam logic [BitIdxW-1:0] LastBit = BitIdxW'(BufferBits - 1);

   logic bit_valid, bit_val, se0, bus_reset;

   usb_fs_line_sampler u_sampler (
      .clk_i       (clock48),
      .rst_ni      (reset_n),
      .dp_i        (data),
      .dn_i        (data_n),
      .bit_valid_o (bit_valid),
      .bit_o       (bit_val),
      .se0_o       (se0),
      .bus_reset_o (bus_reset)
   );

   cap_state_e           state_q, state_d;
   logic [7:0]           shift_q, shift_d;
   logic [BitIdxW-1:0]   bit_idx_q, bit_idx_d;
   logic [ByteCntW-1:0]  byte_count_q, byte_count_d;
   logic                 r_q, r_d, g_q, g_d, b_q, b_d, pullup_q;
   logic                 buf_we;
   logic [WordW-1:0]     buf_word;
   logic [4:0]           buf_bit;

   logic [31:0] usb_packet_buffer [BUFFER_WORDS];

   always_ff @(posedge clock48 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus_reset) begin
         state_d = StIdle;
      end else if (bit_valid) begin
         case (state_q)
            StIdle:     if (!se0 && bit_val) state_d = StSyncHunt;
            StSyncHunt: begin
               if (se0) begin
                  state_d = StIdle;
               end else if ({shift_q[6:0], bit_val} == SYNC_PATTERN) begin
                  state_d = StReceive;
               end
            end
            StReceive: begin
               if (se0) begin
                  state_d = StIdle;
               end else if (bit_idx_q == LastBit) begin
                  state_d = StOverflow;
               end
            end
            StOverflow: if (se0) state_d = StIdle;
            default:    state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      shift_d      = shift_q;
      bit_idx_d    = bit_idx_q;
      byte_count_d = byte_count_q;
      r_d          = r_q;
      g_d          = g_q;
      b_d          = b_q;
      buf_we       = 1'b0;
      if (bus_reset) begin
         b_d          = 1'b1;
         byte_count_d = '0;
         shift_d      = '1;
      end else if (bit_valid) begin
         case (state_q)
            StIdle: shift_d = '1;
            StSyncHunt: begin
               if (!se0) begin
                  shift_d = {shift_q[6:0], bit_val};
                  if (shift_d == SYNC_PATTERN) begin
                     bit_idx_d = '0;
                     g_d       = 1'b0;
                  end
               end
            end
            StReceive: begin
               if (se0) begin
                  byte_count_d = ByteCntW'((bit_idx_q + BitIdxW'(7)) >> 3);
                  g_d          = 1'b1;
               end else begin
                  buf_we    = 1'b1;
                  bit_idx_d = bit_idx_q + BitIdxW'(1);
                  if (bit_idx_q == LastBit) r_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock48 or negedge reset_n) begin
      if (!reset_n) begin
         shift_q      <= '1;
         bit_idx_q    <= '0;
         byte_count_q <= '0;
         r_q          <= 1'b0;
         g_q          <= 1'b0;
         b_q          <= 1'b0;
         pullup_q     <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         bit_idx_q    <= bit_idx_d;
         byte_count_q <= byte_count_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
         pullup_q     <= 1'b1;
      end
   end

   assign buf_word = bit_idx_q[WordW+4:5];
   assign buf_bit  = bit_idx_q[4:0];

   // Buffer contents deliberately survive reset.
   always_ff @(posedge clock48) begin
      if (buf_we) begin
         usb_packet_buffer[buf_word][buf_bit] <= bit_val;
      end
   end

   assign usb_pullup = pullup_q;
   assign r          = r_q;
   assign g          = g_q;
   assign b          = b_q;

endmodule

// File: tb/tb_usb_top.sv
// Bench for usb_top: drives full-speed line states, queues expected packets and
// checks buffer/byte-count/LED state when the DUT signals completion or overflow.
`timescale 1ns / 1ps
module tb_usb_top;

   logic clock48 = 1'b0;
   logic reset_n = 1'b0;
   logic data    = 1'b0;
   logic data_n  = 1'b0;
   logic usb_pullup, r, g, b;

   usb_top dut (
      .clock48    (clock48),
      .reset_n    (reset_n),
      .data       (data),
      .data_n     (data_n),
      .usb_pullup (usb_pullup),
      .r          (r),
      .g          (g),
      .b          (b)
   );

   always #10 clock48 = ~clock48;

   int checks = 0;
   int errors = 0;

   // Scoreboard: kind 0 = packet completion (g rise), kind 1 = overflow (r rise).
   int         exp_kind[$];
   int         exp_len[$];
   logic [7:0] exp_bytes[$];
   logic [7:0] tx_bytes[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_event(input int kind);
      int         k, n;
      logic [7:0] eb;
      logic [31:0] w;
      if (exp_kind.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
      end else begin
         k = exp_kind.pop_front();
         n = exp_len.pop_front();
         check("event_kind", kind, k);
         if (kind == 0) check("byte_count", 32'(dut.byte_count_q), n);
         for (int i = 0; i < n; i++) begin
            eb = exp_bytes.pop_front();
            w  = dut.usb_packet_buffer[i / 4];
            check($sformatf("buf_byte%0d", i), 32'(w[8 * (i % 4) +: 8]), 32'(eb));
         end
      end
   endtask

   logic g_prev = 1'b0;
   logic r_prev = 1'b0;
   always @(negedge clock48) begin
      if (g && !g_prev) compare_event(0);
      if (r && !r_prev) compare_event(1);
      g_prev <= g;
      r_prev <= r;
   end

   task automatic line(input logic dp, input logic dn, input int cycles);
      data   = dp;
      data_n = dn;
      repeat (cycles) @(negedge clock48);
   endtask

   task automatic send_bit(input logic v);
      line(v, ~v, 4);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i]);
   endtask

   task automatic send_sync(input logic [7:0] pat);
      for (int i = 7; i >= 0; i--) send_bit(pat[i]);
   endtask

   task automatic eop();
      line(1'b0, 1'b0, 8);
      line(1'b1, 1'b0, 16);
   endtask

   task automatic expect_event(input int kind, input int len);
      exp_kind.push_back(kind);
      exp_len.push_back(len);
   endtask

   task automatic send_tx();
      line(1'b1, 1'b0, 16);
      send_sync(8'b0101_0100);
      while (tx_bytes.size() != 0) send_byte(tx_bytes.pop_front());
      eop();
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (exp_kind.size() != 0 && n < limit) begin
         @(negedge clock48);
         n++;
      end
      checks++;
      if (exp_kind.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending events expected 0", exp_kind.size());
         exp_kind.delete();
         exp_len.delete();
         exp_bytes.delete();
      end
   endtask

   initial begin
      int n;
      // Reset and attach
      repeat (5) @(negedge clock48);
      check("pullup_in_reset", usb_pullup, 0);
      check("rgb_in_reset", {r, g, b}, 3'b000);
      reset_n = 1'b1;
      repeat (3) @(negedge clock48);
      check("pullup_after_reset", usb_pullup, 1);
      check("rgb_after_reset", {r, g, b}, 3'b000);
      line(1'b1, 1'b0, 100);
      check("b_idle_j", b, 0);

      // Bus reset: b must not fire early, must fire near 120 SE0 cycles, then stay set
      line(1'b0, 1'b0, 100);
      check("b_before_threshold", b, 0);
      n = 0;
      while (!b && n < 30) begin
         @(negedge clock48);
         n++;
      end
      check("b_bus_reset", b, 1);
      line(1'b0, 1'b0, 80);
      line(1'b1, 1'b0, 400);
      check("g_after_bus_reset", g, 0);
      check("b_sticky", b, 1);

      // Corrupted SYNC followed by all-J data: nothing captured
      line(1'b1, 1'b0, 16);
      send_sync(8'b0101_0110);
      send_byte(8'hFF);
      send_byte(8'hFF);
      eop();
      check("g_bad_sync", g, 0);
      check("byte_count_bad_sync", 32'(dut.byte_count_q), 0);

      // Two-byte packet
      tx_bytes = '{8'hA5, 8'h3C};
      expect_event(0, 2);
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(8'h3C);
      send_tx();
      drain(50);
      check("g_single", g, 1);

      // Five-byte packet spanning two words
      tx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      expect_event(0, 5);
      for (int i = 1; i <= 5; i++) exp_bytes.push_back(8'(i));
      send_tx();
      drain(50);
      check("word0_five", dut.usb_packet_buffer[0], 32'h0403_0201);

      // 12-bit packet: byte count rounds up, old upper nibble of byte1 (0x02 -> 0x0) kept
      expect_event(0, 2);
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(8'h06);
      line(1'b1, 1'b0, 16);
      send_sync(8'b0101_0100);
      send_byte(8'hA5);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      eop();
      drain(50);

      // Overflow: 1025 bytes, only the first 1024 stored
      expect_event(1, 1024);
      for (int i = 0; i < 1024; i++) exp_bytes.push_back(8'(i));
      for (int i = 0; i < 1025; i++) tx_bytes.push_back(8'(i ^ 1));
      for (int i = 0; i < 1024; i++) exp_bytes[i] = 8'(i ^ 1);
      send_tx();
      drain(50);
      check("r_overflow", r, 1);
      check("g_overflow", g, 0);

      // Recovery packet after overflow
      tx_bytes = '{8'h5A, 8'hC3};
      expect_event(0, 2);
      exp_bytes.push_back(8'h5A);
      exp_bytes.push_back(8'hC3);
      send_tx();
      drain(50);
      check("g_recovery", g, 1);
      check("r_sticky", r, 1);

      // Asynchronous reset clears LEDs and pull-up
      #3 reset_n = 1'b0;
      #2;
      check("rgb_async_reset", {r, g, b}, 3'b000);
      check("pullup_async_reset", usb_pullup, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/usb_top.md
Name: usb_top

Overview:
- Top-level USB full-speed (12 Mb/s) raw packet capture block for the FPGA board.
- Runs from the 48 MHz board clock and asserts the D+ pull-up to attach as a full-speed device.
- Oversamples D+/D- 4x, recovers bit timing, detects bus reset, SYNC and EOP, and stores the raw line-state bits of each packet into a word-addressed packet buffer.
- Drives an RGB status LED.

Parameters:
- BUFFER_WORDS, 256, depth of usb_packet_buffer in 32-bit words (1024 bytes).
- SAMPLES_PER_BIT, 4, clock48 cycles per full-speed bit.
- BUS_RESET_CYCLES, 120, consecutive SE0 clock48 cycles (2.5 us) that count as a bus reset.

Ports:
- clock48  input  1  48 MHz clock; the only clock.
- reset_n  input  1  asynchronous, active-low reset.
- data  input  1  USB D+ line level.
- data_n  input  1  USB D- line level.
- usb_pullup  output  1  D+ 1.5k pull-up enable; 1 = attached.
- r  output  1  red LED, active-high: buffer overflow occurred.
- g  output  1  green LED, active-high: complete packet captured.
- b  output  1  blue LED, active-high: bus reset detected.

Behaviour:
- Reset: usb_pullup, r, g, b = 0; byte/bit counters = 0; state = IDLE. Buffer contents are not reset.
- After reset_n deasserts, usb_pullup = 1 constantly.
- Input synchronisation:
  - data and data_n each pass through a 2-flop synchroniser before any use.
  - Line states: J = (1,0); K = (0,1); SE0 = (0,0); (1,1) is treated as SE0.
- Bit timing:
  - A 2-bit phase counter resets to 0 on every J/K transition and otherwise increments mod 4.
  - The line is sampled when phase == 2, which is mid-bit.
- Bus reset:
  - SE0 lasting BUS_RESET_CYCLES or more sets b = 1, forces state IDLE and clears the byte count.
  - b stays set until reset_n.
- State machine:
  - IDLE: wait for one sampled J bit → SYNC_HUNT.
  - SYNC_HUNT: shift sampled line bits (J = 1, K = 0) into an 8-bit register; a match of 0b01010100 (first-received bit in the MSB: K J K J K J K K) → RECEIVE, with the bit index cleared and g cleared. An SE0 sample → IDLE.
  - RECEIVE:
    - Each non-SE0 sampled bit n (J = 1, K = 0) is written to usb_packet_buffer[n/32] bit (n mod 32); bit j of byte i therefore lands at word i/4, bit 8·(i mod 4)+j, LSB first.
    - No NRZI decoding and no bit unstuffing: raw line states are stored, and firmware decodes them.
    - An SE0 sample ends the packet: the byte count is latched as ceil(bits/8), g = 1, → IDLE.
    - A partial final byte keeps its already-written bits; the remaining bits are unchanged.
- Overflow: a bit index reaching BUFFER_WORDS·32 stops further writes, sets r = 1 (sticky until reset_n), and the state waits for SE0 → IDLE.
- Buffer:
  - A hierarchically visible array named usb_packet_buffer, BUFFER_WORDS × 32 bits, written one bit per received bit (read-modify-write or bit-enable).
  - Benches read it directly.
- Reset mid-packet: asynchronous reset aborts the capture immediately; written buffer bits remain.

Decomposition:
- Shared package holds:
  - line-state encoding constants (J, K, SE0);
  - SYNC_PATTERN = 8'b01010100;
  - the full-speed timing constants (SAMPLES_PER_BIT, BUS_RESET_CYCLES).
- One natural sub-module: usb_fs_line_sampler, containing:
  - the synchronisers;
  - line-state decode;
  - the phase counter;
  - SE0 run-length bus-reset detection.
- It outputs a bit-valid strobe, the bit value, an SE0 flag and a bus_reset pulse.
- Capture FSM, buffer and LEDs stay in usb_top.

Test Plan:
- Reset/attach: reset_n low then high, lines SE0 → usb_pullup = 0 during reset and 1 after; r = g = b = 0.
- Bus reset: SE0 for 30 ms → b = 1 within 120 cycles of SE0 start; then J idle 10 ms → no packet, g = 0.
- Single packet: after idle J, send the SYNC line sequence 0,1,0,1,0,1,0,0 (83.33 ns per bit, where 1 = J), then bytes 0xA5, 0x3C LSB-first as line levels, then SE0 for 2 bit times → usb_packet_buffer[0][15:0] = 16'h3CA5, g = 1, byte count = 2.
- Five-byte packet 0x01, 0x02, 0x03, 0x04, 0x05 → word0 = 32'h04030201, word1[7:0] = 8'h05.
- Sync corruption: line sequence 0,1,0,1,0,1,1,0 followed by data → no buffer writes, g stays 0.
- Overflow: send 1025 bytes → bytes 0..1023 stored, r = 1, g = 0 until the next valid packet completes.
